// File: rtl/pll_reset_seq_if.sv
// Status/control bundle between the PLL reset sequencer and its surroundings.
// master: the sequencer (samples pll_lock, drives everything else).
// slave : the environment (rPLL lock source and reset consumers).
interface pll_reset_seq_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             pll_rst;
    logic             sys_rst;
    logic             locked;
    logic             timeout_err;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        input  pll_lock,
        output pll_rst, sys_rst, locked, timeout_err, retry_cnt, loss_cnt
    );

    modport slave (
        output pll_lock,
        input  pll_rst, sys_rst, locked, timeout_err, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/pll_reset_seq.sv
// Reset/lock sequencer for the Gowin rPLL, clocked from the free-running
// crystal so it keeps running while the PLL is unlocked.
// Pulses pll_rst, waits for lock with timeout/retry, holds sys_rst until lock
// has been stable, and re-sequences on lock loss while counting events.
// Optional build macro: PLL_RST_SEQ_GLITCH_FILTER_EN -- when defined, a loss
// in RUN needs GLITCH_CYCLES consecutive low synced-lock cycles.
module pll_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 2700,
    parameter int GLITCH_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic           clk,
    input  logic           rst,
    pll_reset_seq_if.master bus
);
    localparam int MAX_RT  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] S_PLL_RST   = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_STABLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 ||
        GLITCH_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("pll_reset_seq: parameter out of range");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             lock_s_q, lock_s_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             locked_q, locked_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             loss_evt;

`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
    localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [GW-1:0] GL_LAST = GW'(GLITCH_CYCLES - 1);
    logic [GW-1:0] glitch_q, glitch_d;
`endif

    // Next-state, counters and outputs decoded from the next state
    always_comb begin
        sync1_d       = bus.pll_lock;
        lock_s_d      = sync1_q;
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        timeout_err_d = timeout_err_q;
        retry_cnt_d   = retry_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        loss_evt      = 1'b0;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
        // count consecutive low samples in RUN; any high sample clears it
        glitch_d = '0;
        if (state_q == S_RUN && !lock_s_q) begin
            if (glitch_q == GL_LAST) loss_evt = 1'b1;
            else                     glitch_d = glitch_q + 1'b1;
        end
`else
        loss_evt = (state_q == S_RUN) && !lock_s_q;
`endif
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d       = S_PLL_RST;
                    timeout_err_d = 1'b1;
                    if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                // a drop wins over reaching the stable count
                if (!lock_s_q)              state_d = S_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = S_RUN;
            end
            default: begin
                cnt_d = cnt_q;
                if (loss_evt) begin
                    state_d = S_PLL_RST;
                    if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
                end
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        pll_rst_d = (state_d == S_PLL_RST);
        sys_rst_d = (state_d != S_RUN);
        locked_d  = (state_d == S_RUN);
    end

    // State, synchronizer and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_PLL_RST;
            cnt_q         <= '0;
            sync1_q       <= 1'b0;
            lock_s_q      <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            locked_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            retry_cnt_q   <= '0;
            loss_cnt_q    <= '0;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
            glitch_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync1_q       <= sync1_d;
            lock_s_q      <= lock_s_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_q     <= sys_rst_d;
            locked_q      <= locked_d;
            timeout_err_q <= timeout_err_d;
            retry_cnt_q   <= retry_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
            glitch_q      <= glitch_d;
`endif
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.locked      = locked_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.retry_cnt   = retry_cnt_q;
    assign bus.loss_cnt    = loss_cnt_q;
endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed steps plus randomized lock patterns,
// every cycle compared against a phase/duration reference model.
module tb_pll_reset_seq;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int GLITCH_CYCLES = 3;
    localparam int CNT_W         = 8;
    localparam int SAT           = (1 << CNT_W) - 1;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
    localparam int LOSS_RUN = GLITCH_CYCLES;
`else
    localparam int LOSS_RUN = 1;
`endif

    typedef enum int {M_PULSE, M_WAIT, M_SETTLE, M_RUN} mphase_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pll_reset_seq_if #(.CNT_W(CNT_W)) bus ();

    pll_reset_seq #(
        .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES), .GLITCH_CYCLES(GLITCH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: current phase, cycles spent in it, lock history
    mphase_t ph = M_PULSE;
    int   age     = 0;
    int   lowrun  = 0;
    logic m_err   = 1'b0;
    int   retries = 0;
    int   losses  = 0;
    logic [1:0] hist = 2'b00;

    function automatic void model_step(input logic r, input logic lk);
        logic seen;
        if (r) begin
            ph = M_PULSE; age = 0; lowrun = 0; m_err = 1'b0;
            retries = 0; losses = 0; hist = 2'b00;
            return;
        end
        seen = hist[1];
        hist = {hist[0], lk};
        case (ph)
            M_PULSE: begin
                age++;
                if (age == RST_CYCLES) begin ph = M_WAIT; age = 0; end
            end
            M_WAIT: begin
                if (seen) begin
                    ph = M_SETTLE; age = 0;
                end else begin
                    age++;
                    if (age == LOCK_TIMEOUT) begin
                        ph = M_PULSE; age = 0; m_err = 1'b1;
                        retries = (retries < SAT) ? retries + 1 : SAT;
                    end
                end
            end
            M_SETTLE: begin
                if (!seen) begin
                    ph = M_WAIT; age = 0;
                end else begin
                    age++;
                    if (age == STABLE_CYCLES) begin ph = M_RUN; age = 0; lowrun = 0; end
                end
            end
            default: begin
                lowrun = seen ? 0 : lowrun + 1;
                if (lowrun >= LOSS_RUN) begin
                    ph = M_PULSE; age = 0;
                    losses = (losses < SAT) ? losses + 1 : SAT;
                end
            end
        endcase
    endfunction

    function automatic logic [19:0] outs();
        return {bus.pll_rst, bus.sys_rst, bus.locked, bus.timeout_err,
                bus.retry_cnt, bus.loss_cnt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [19:0] e;
        @(posedge clk);
        model_step(rst, bus.pll_lock);
        #1;
        e = {ph == M_PULSE, ph != M_RUN, ph == M_RUN, m_err,
             8'(retries), 8'(losses)};
        check("cycle", {12'd0, outs()}, {12'd0, e});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ph(input mphase_t p, input int lim, input string tag);
        int k = 0;
        while (ph != p && k < lim) begin tick(); k++; end
        check(tag, {31'd0, ph == p}, 32'd1);
    endtask

    localparam logic [19:0] RST_OUTS = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};

    int n;
    int saved;

    initial begin
        // 1: reset with lock held high, then pulse length and lock latency
        bus.pll_lock = 1'b1;
        rst = 1'b1;
        run(3);
        check("reset_outs", {12'd0, outs()}, {12'd0, RST_OUTS});
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.pll_rst && n < 40);
        check("pll_rst_edges", n, RST_CYCLES);
        while (!bus.locked && n < 60) begin tick(); n++; end
        check("lock_latency", n, RST_CYCLES + 1 + STABLE_CYCLES);
        check("sys_rst_run", {31'd0, bus.sys_rst}, 32'd0);

        // 6a: reset mid-RUN
        run(3);
        rst = 1'b1;
        tick();
        check("reset_mid_run", {12'd0, outs()}, {12'd0, RST_OUTS});
        rst = 1'b0;

        // 2: lock never arrives, three timeouts
        bus.pll_lock = 1'b0;
        run(3 * (RST_CYCLES + LOCK_TIMEOUT) + 3);
        check("timeout_err", {31'd0, bus.timeout_err}, 32'd1);
        check("retry_3", {24'd0, bus.retry_cnt}, 32'd3);

        // 3: lock drops so the synced low lands on the final STABLE count
        saved = 3;
        bus.pll_lock = 1'b1;
        wait_ph(M_SETTLE, 60, "reach_settle");
        run(STABLE_CYCLES - 3);
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        run(2);
        check("settle_drop_locked", {31'd0, bus.locked}, 32'd0);
        check("settle_drop_loss", {24'd0, bus.loss_cnt}, 32'd0);
        check("settle_drop_retry", {24'd0, bus.retry_cnt}, saved);

        // 4: single-cycle low pulse in RUN, then a GLITCH_CYCLES pulse
        wait_ph(M_RUN, 60, "reach_run");
        run(2);
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        run(6);
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
        check("short_glitch_loss", {24'd0, bus.loss_cnt}, 32'd0);
        check("short_glitch_locked", {31'd0, bus.locked}, 32'd1);
        bus.pll_lock = 1'b0;
        run(GLITCH_CYCLES);
        bus.pll_lock = 1'b1;
        run(6);
`endif
        check("loss_1", {24'd0, bus.loss_cnt}, 32'd1);
        check("loss_relock", {31'd0, bus.locked}, 32'd0);

        // 6b: reset mid-STABLE
        wait_ph(M_SETTLE, 60, "reach_settle2");
        run(3);
        rst = 1'b1;
        tick();
        check("reset_mid_stable", {12'd0, outs()}, {12'd0, RST_OUTS});
        rst = 1'b0;

        // randomized lock segments with occasional reset
        for (int s = 0; s < 150; s++) begin
            int len;
            len = $urandom_range(1, 25);
            bus.pll_lock = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            tick();
            rst = 1'b0;
            run(len - 1);
        end

        // 5: saturate loss counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.pll_lock = 1'b1;
            wait_ph(M_RUN, 60, "sat_run");
            bus.pll_lock = 1'b0;
            run(GLITCH_CYCLES + 2);
        end
        check("loss_sat", {24'd0, bus.loss_cnt}, SAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
